keypad_encoder: RTL and testbench
=================================

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 120000: sample-tick period in clk cycles (10 ms at 12 MHz); legal range 2..131071.
REQ-002 SHALL have port clk  input  1  system clock (hz12M); all state on rising edge.
REQ-003 SHALL have port n_rst  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port en  input  1  output enable; 0 forces keycode=0 and suppresses pulses.
REQ-005 SHALL have port keypad_i  input  15  raw active-high buttons; [12:0] note keys, [13] mode key, [14] sound-series key.
REQ-006 SHALL have port keycode  output  4  registered note code; 0 = no note, 1..13 = note key index+1.
REQ-007 SHALL have port mode_key  output  1  one-cycle pulse per accepted press of keypad_i[13].
REQ-008 SHALL have port sound_edge  output  1  one-cycle pulse per accepted press of keypad_i[14].

Function
REQ-009 SHALL pass all 15 inputs through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-010 SHALL hold a 15-bit debounced state vector "stable"; all outputs derive only from stable.
REQ-011 SHALL (debounce enabled) run a free-running tick counter 0..DEBOUNCE_CYCLES-1, wrapping to 0; tick asserted when count = DEBOUNCE_CYCLES-1.
REQ-012 SHALL on each tick: samp <= sync2; per bit, if sync2 equals samp then stable <= sync2, else stable bit unchanged.
REQ-013 SHALL therefore accept a level change only after it is seen on two consecutive ticks; glitches shorter than one tick period never change stable.
REQ-014 SHALL compute keycode as priority encode of stable[12:0]: lowest-index set bit wins; multiple notes held -> lowest index; none -> 0.
REQ-015 SHALL register keycode and the pulses one cycle after stable updates (stable_d holds the previous stable).
REQ-016 SHALL assert mode_key for exactly one clk when stable[13]=1 and stable_d[13]=0 and en=1; likewise sound_edge for bit 14.
REQ-017 SHALL produce no pulse on release, and at most one pulse per press however long held.
REQ-018 SHALL, with en=0, drive keycode=0, mode_key=0, sound_edge=0 while synchronizer, counter and stable continue updating; a key already stable-high when en rises produces no pulse.
REQ-019 SHALL let simultaneous mode and sound-series presses both pulse in the same cycle, independent of note keys.

Reset
REQ-020 SHALL on n_rst=0 asynchronously clear sync1, sync2, samp, stable, stable_d, tick counter, keycode, mode_key, sound_edge to 0.
REQ-021 SHALL on reset mid-operation abandon the debounce in progress; a key held through reset release is re-accepted from zero and yields one press pulse after normal latency.

Configuration
REQ-022 SHALL compile debounce logic only when macro KEYPAD_DEBOUNCE_EN is defined (REQ-011..013 apply).
REQ-023 SHALL, without KEYPAD_DEBOUNCE_EN, omit the tick counter and samp and load stable <= sync2 every clk; DEBOUNCE_CYCLES is then ignored.
REQ-024 SHALL give latency, without debounce, of exactly 4 rising clk edges from a keypad_i change to keycode/pulse change.

Verification
REQ-025 SHALL cover: no macro, en=1, keypad_i=15'h0004 from idle -> keycode=3 on 4th rising edge, mode_key/sound_edge stay 0.
REQ-026 SHALL cover: no macro, keypad_i=15'h0006 then 15'h1000 -> keycode 2 then 13; keypad_i=0 -> keycode 0.
REQ-027 SHALL cover: macro, DEBOUNCE_CYCLES=4, 3-cycle pulse on bit 13 between ticks -> no mode_key; bit 13 held 20 cycles -> exactly one mode_key pulse within 2 tick periods+4 cycles.
REQ-028 SHALL cover: keypad_i=15'h6000 held -> mode_key and sound_edge pulse together once; release -> no pulses.
REQ-029 SHALL cover: en=0 while keypad_i=15'h2001 settles -> outputs all 0; en->1 -> keycode=1, no mode_key pulse.
REQ-030 SHALL cover: n_rst pulsed low mid-hold of bit 14 -> all outputs 0 asynchronously; after release one sound_edge pulse.

Source files
------------

// File: rtl/keypad_encoder.sv
`timescale 1ns / 1ps
// keypad_encoder
//
// Turns a 15-button raw keypad into a registered note code plus two one-shot
// press pulses. Every input is synchronised, optionally debounced, and kept in
// a "stable" vector; all outputs are derived from that vector only.
//
// Optional feature: define KEYPAD_DEBOUNCE_EN to build the tick-based
// debouncer. Without it, stable follows the synchroniser every clock and
// DEBOUNCE_CYCLES has no effect (it is only range-checked).
//
// Parameters
//   DEBOUNCE_CYCLES  sample-tick period in clk cycles (legal 2..131071)
//
// Ports
//   clk         system clock, all state on the rising edge
//   n_rst       asynchronous active-low reset
//   en          output enable; low forces keycode=0 and suppresses pulses
//   keypad_i    raw active-high buttons: [12:0] notes, [13] mode, [14] sound series
//   keycode     0 = no note, 1..13 = lowest held note index + 1
//   mode_key    one-clock pulse per accepted press of keypad_i[13]
//   sound_edge  one-clock pulse per accepted press of keypad_i[14]

module keypad_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        en,
    input  logic [14:0] keypad_i,
    output logic [3:0]  keycode,
    output logic        mode_key,
    output logic        sound_edge
);

    // The tick counter is 17 bits wide, which bounds the legal period.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 131071) begin : g_bad_debounce_cycles
        $error("keypad_encoder: DEBOUNCE_CYCLES must be within 2..131071");
    end

    // ------------------------------------------------------------------
    // Two-flop synchroniser
    // ------------------------------------------------------------------
    logic [14:0] sync1_q;
    logic [14:0] sync2_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= keypad_i;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Stable (debounced) state
    // ------------------------------------------------------------------
    logic [14:0] stable_q;
    logic [14:0] stable_d;

`ifdef KEYPAD_DEBOUNCE_EN
    localparam logic [16:0] TickLast = 17'(DEBOUNCE_CYCLES - 1);

    logic [16:0] cnt_q;
    logic [16:0] cnt_d;
    logic [14:0] samp_q;
    logic [14:0] samp_d;
    logic [14:0] agree;
    logic        tick;

    always_comb begin
        tick   = (cnt_q == TickLast);
        cnt_d  = tick ? '0 : cnt_q + 17'd1;
        samp_d = samp_q;
        // A bit is accepted only when the current tick sample matches the
        // previous tick sample, so anything shorter than a tick period is lost.
        agree    = ~(sync2_q ^ samp_q);
        stable_d = stable_q;
        if (tick) begin
            samp_d   = sync2_q;
            stable_d = (agree & sync2_q) | (~agree & stable_q);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q  <= '0;
            samp_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            samp_q <= samp_d;
        end
    end
`else
    always_comb begin
        stable_d = sync2_q;
    end
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stable_q <= '0;
        end else begin
            stable_q <= stable_d;
        end
    end

    // ------------------------------------------------------------------
    // Output stage: one cycle behind stable
    // ------------------------------------------------------------------
    // stable_prev_q holds stable from the previous clock for edge detection.
    logic [14:0] stable_prev_q;
    logic [3:0]  note_code;
    logic [3:0]  keycode_q;
    logic [3:0]  keycode_d;
    logic        mode_q;
    logic        mode_d;
    logic        sound_q;
    logic        sound_d;

    // Lowest-index held note wins: scan downwards so the last hit is lowest.
    always_comb begin
        note_code = 4'd0;
        for (int i = 12; i >= 0; i--) begin
            if (stable_q[i]) begin
                note_code = 4'(i + 1);
            end
        end
    end

    always_comb begin
        keycode_d = en ? note_code : 4'd0;
        // A key already high when en rises has stable_prev_q set, so no pulse.
        mode_d    = en & stable_q[13] & ~stable_prev_q[13];
        sound_d   = en & stable_q[14] & ~stable_prev_q[14];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stable_prev_q <= '0;
            keycode_q     <= '0;
            mode_q        <= 1'b0;
            sound_q       <= 1'b0;
        end else begin
            stable_prev_q <= stable_q;
            keycode_q     <= keycode_d;
            mode_q        <= mode_d;
            sound_q       <= sound_d;
        end
    end

    assign keycode    = keycode_q;
    assign mode_key   = mode_q;
    assign sound_edge = sound_q;

endmodule

// File: tb/tb_keypad_encoder.sv
`timescale 1ns / 1ps
// Self-checking bench for keypad_encoder. Works in either build; the
// debounce-specific scenario is selected by KEYPAD_DEBOUNCE_EN.

module tb_keypad_encoder;

    localparam int unsigned D = 4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        en = 1'b1;
    logic [14:0] keypad_i = '0;
    logic [3:0]  keycode;
    logic        mode_key;
    logic        sound_edge;

    int total = 0;
    int bad = 0;

    keypad_encoder #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .en         (en),
        .keypad_i   (keypad_i),
        .keycode    (keycode),
        .mode_key   (mode_key),
        .sound_edge (sound_edge)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: inputs reach the debouncer two edges after capture,
    // debounced state changes on ticks (every D-th edge since reset) when two
    // successive tick samples agree, outputs follow one edge later.
    // ------------------------------------------------------------------
    int unsigned m_edges = 0;
    logic [14:0] m_h1 = '0, m_h2 = '0, m_samp = '0, m_stable = '0, m_prev = '0;
    logic [3:0]  exp_kc = '0;
    logic        exp_mode = 1'b0, exp_snd = 1'b0;

    function automatic bit is_tick(int unsigned n);
`ifdef KEYPAD_DEBOUNCE_EN
        return (n % D) == 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [14:0] next_stable(logic [14:0] cur, logic [14:0] samp,
                                                logic [14:0] seen, int unsigned n);
        logic [14:0] r;
        r = cur;
`ifdef KEYPAD_DEBOUNCE_EN
        if (is_tick(n)) begin
            for (int b = 0; b < 15; b++) begin
                if (seen[b] == samp[b]) r[b] = seen[b];
            end
        end
`else
        r = seen;
`endif
        return r;
    endfunction

    function automatic logic [3:0] lowest_note(logic [14:0] s);
        for (int i = 0; i < 13; i++) begin
            if (s[i]) return 4'(i + 1);
        end
        return 4'd0;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_edges  <= 0;
            m_h1     <= '0;
            m_h2     <= '0;
            m_samp   <= '0;
            m_stable <= '0;
            m_prev   <= '0;
            exp_kc   <= '0;
            exp_mode <= 1'b0;
            exp_snd  <= 1'b0;
        end else begin
            m_stable <= next_stable(m_stable, m_samp, m_h2, m_edges + 1);
            m_samp   <= is_tick(m_edges + 1) ? m_h2 : m_samp;
            m_prev   <= m_stable;
            exp_kc   <= en ? lowest_note(m_stable) : 4'd0;
            exp_mode <= en & m_stable[13] & ~m_prev[13];
            exp_snd  <= en & m_stable[14] & ~m_prev[14];
            m_h2     <= m_h1;
            m_h1     <= keypad_i;
            m_edges  <= m_edges + 1;
        end
    end

    // ------------------------------------------------------------------
    task automatic test_reset();
        #2;
        total++;
        if (keycode !== 4'd0) begin
            bad++;
            $display("FAIL reset_keycode: got %0d want 0", keycode);
        end
        total++;
        if (mode_key !== 1'b0 || sound_edge !== 1'b0) begin
            bad++;
            $display("FAIL reset_pulses: got mode=%b sound=%b want 0 0", mode_key, sound_edge);
        end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic idle(int n);
        @(negedge clk);
        keypad_i = '0;
        repeat (n) @(negedge clk);
    endtask

`ifndef KEYPAD_DEBOUNCE_EN
    task automatic test_latency();
        idle(8);
        en = 1'b1;
        keypad_i = 15'h0004;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            total++;
            if (keycode !== ((e >= 4) ? 4'd3 : 4'd0)) begin
                bad++;
                $display("FAIL latency_edge%0d: got %0d want %0d", e, keycode,
                         (e >= 4) ? 3 : 0);
            end
            total++;
            if (mode_key !== 1'b0 || sound_edge !== 1'b0) begin
                bad++;
                $display("FAIL latency_pulses_edge%0d: got mode=%b sound=%b want 0 0",
                         e, mode_key, sound_edge);
            end
        end
    endtask

    task automatic test_priority();
        logic [14:0] pats [3] = '{15'h0006, 15'h1000, 15'h0000};
        logic [3:0]  want [3] = '{4'd2, 4'd13, 4'd0};
        for (int p = 0; p < 3; p++) begin
            keypad_i = pats[p];
            repeat (5) @(negedge clk);
            total++;
            if (keycode !== want[p]) begin
                bad++;
                $display("FAIL priority_%h: got %0d want %0d", pats[p], keycode, want[p]);
            end
        end
    endtask
`else
    task automatic test_debounce();
        int pulses;
        int first;
        idle(3 * D);
        // Short glitch on the mode key, shorter than one tick period.
        keypad_i = 15'h2000;
        repeat (3) @(negedge clk);
        keypad_i = '0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (mode_key === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL debounce_glitch: got %0d pulses want 0", pulses);
        end
        // Long hold: exactly one pulse, within 2 tick periods + 4 cycles.
        keypad_i = 15'h2000;
        pulses = 0;
        first = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mode_key === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        keypad_i = '0;
        repeat (20) begin
            @(negedge clk);
            if (mode_key === 1'b1) pulses++;
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL debounce_hold_count: got %0d pulses want 1", pulses);
        end
        total++;
        if (first < 1 || first > 2 * D + 4) begin
            bad++;
            $display("FAIL debounce_hold_latency: got cycle %0d want 1..%0d", first, 2 * D + 4);
        end
    endtask
`endif

    task automatic test_both_pulses();
        int nm, ns, together;
        idle(3 * D + 6);
        en = 1'b1;
        keypad_i = 15'h6000;
        nm = 0; ns = 0; together = 0;
        repeat (30) begin
            @(negedge clk);
            if (mode_key === 1'b1) nm++;
            if (sound_edge === 1'b1) ns++;
            if (mode_key === 1'b1 && sound_edge === 1'b1) together++;
        end
        total++;
        if (nm != 1 || ns != 1 || together != 1) begin
            bad++;
            $display("FAIL both_press: got mode=%0d sound=%0d together=%0d want 1 1 1",
                     nm, ns, together);
        end
        keypad_i = '0;
        nm = 0; ns = 0;
        repeat (30) begin
            @(negedge clk);
            if (mode_key === 1'b1) nm++;
            if (sound_edge === 1'b1) ns++;
        end
        total++;
        if (nm != 0 || ns != 0) begin
            bad++;
            $display("FAIL both_release: got mode=%0d sound=%0d want 0 0", nm, ns);
        end
    endtask

    task automatic test_enable();
        int nz;
        int nm;
        idle(3 * D + 6);
        en = 1'b0;
        keypad_i = 15'h2001;
        nz = 0;
        repeat (30) begin
            @(negedge clk);
            if (keycode !== 4'd0 || mode_key !== 1'b0 || sound_edge !== 1'b0) nz++;
        end
        total++;
        if (nz != 0) begin
            bad++;
            $display("FAIL enable_low: got %0d nonzero cycles want 0", nz);
        end
        en = 1'b1;
        @(negedge clk);
        total++;
        if (keycode !== 4'd1) begin
            bad++;
            $display("FAIL enable_rise_keycode: got %0d want 1", keycode);
        end
        nm = (mode_key === 1'b1) ? 1 : 0;
        repeat (10) begin
            @(negedge clk);
            if (mode_key === 1'b1) nm++;
        end
        total++;
        if (nm != 0) begin
            bad++;
            $display("FAIL enable_rise_mode: got %0d pulses want 0", nm);
        end
    endtask

    task automatic test_reset_mid();
        int ns;
        idle(3 * D + 6);
        en = 1'b1;
        keypad_i = 15'h4000;
        repeat (30) @(negedge clk);
        keypad_i = 15'h4001;
        repeat (30) @(negedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        total++;
        if (keycode !== 4'd0 || mode_key !== 1'b0 || sound_edge !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_async: got kc=%0d mode=%b sound=%b want 0 0 0",
                     keycode, mode_key, sound_edge);
        end
        @(negedge clk);
        n_rst = 1'b1;
        ns = 0;
        repeat (40) begin
            @(negedge clk);
            if (sound_edge === 1'b1) ns++;
        end
        total++;
        if (ns != 1) begin
            bad++;
            $display("FAIL reset_mid_repress: got %0d pulses want 1", ns);
        end
        total++;
        if (keycode !== 4'd1) begin
            bad++;
            $display("FAIL reset_mid_keycode: got %0d want 1", keycode);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            total++;
            if (keycode !== exp_kc || mode_key !== exp_mode || sound_edge !== exp_snd) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle%0d: got kc=%0d m=%b s=%b want kc=%0d m=%b s=%b",
                             c, keycode, mode_key, sound_edge, exp_kc, exp_mode, exp_snd);
            end
            if ($urandom_range(0, 5) == 0)
                keypad_i = 15'($urandom) & 15'($urandom) & 15'($urandom);
            if ($urandom_range(0, 19) == 0) en = ~en;
        end
    endtask

    initial begin
        test_reset();
`ifndef KEYPAD_DEBOUNCE_EN
        test_latency();
        test_priority();
`else
        test_debounce();
`endif
        test_both_pulses();
        test_enable();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
